uart_ssd_scan_display: RTL and testbench
========================================

# uart_ssd_scan_display

Multi-digit, parametrised successor to the two-digit UART byte display. Bytes from the UART receiver (`rx_data`/`rx_valid`) go into a display buffer of `NUM_BYTES` entries, and each byte is shown as two hex digits on a time-multiplexed seven-segment bank. The block sits between `uart_communication` and the SSD pins. It adds a real scan prescaler, anti-ghosting blanking, shift or overwrite buffer modes, and per-digit "never written" dashes.

## Interface
- `NUM_BYTES`, 2: buffer depth in bytes; digit count = 2*`NUM_BYTES` (range 1–8).
- `SCAN_DIV`, 416_667: clk cycles per digit slot, including blanking; must be ≥ `BLANK_CYCLES`+1.
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all digits off.
- `SHIFT_MODE`, 1: 1 = new byte enters entry 0 and older bytes shift up; 0 = write at a wrapping pointer.
- `SEG_ACTIVE_LOW`, 1: polarity of `segments`. `dig_sel` is always active-low.
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `segments` out 7: {g,f,e,d,c,b,a}, registered.
- `dig_sel` out 2*`NUM_BYTES`: one-hot active-low digit enable, registered.

## Operation
- Buffer: `NUM_BYTES` × 8-bit `byte_q` plus a `written` flag per entry. Digit 2k shows `byte_q[k][3:0]` and digit 2k+1 shows `byte_q[k][7:4]`. Digit 0 is the rightmost.
- Shift mode: on `rx_valid`, `byte_q[k] <= byte_q[k-1]` for k≥1 and `byte_q[0] <= rx_data`. Flags shift the same way, and `written[0] <= 1`. The oldest entry is discarded.
- Overwrite mode: on `rx_valid`, `byte_q[wr_ptr] <= rx_data`, `written[wr_ptr] <= 1`, and `wr_ptr` increments, wrapping from `NUM_BYTES`-1 to 0.
- A digit whose entry has `written`=0 displays a dash (segment g only).
- The decoder maps 0–F to standard hex glyphs, with lowercase b and d.
- Scanner:
  - `div_cnt` counts 0..`SCAN_DIV`-1.
  - At terminal count, `dig_idx` advances and wraps from 2*`NUM_BYTES`-1 to 0.
  - States: BLANK while `div_cnt` < `BLANK_CYCLES`, otherwise DRIVE.
- BLANK: `dig_sel` = all ones. DRIVE: `dig_sel` = ~(1<<`dig_idx`).
- `segments` is registered every cycle from the glyph for `dig_idx`. Data changes therefore take effect mid-slot; no slot-boundary latching.
- `rst` wins over `rx_valid`. `rx_valid` and the scan terminal count in the same cycle are both honoured.

## Timing
- Reset values:
  - `div_cnt`=0, `dig_idx`=0, `wr_ptr`=0, all `written`=0, `byte_q`=0.
  - `dig_sel` = all ones (BLANK, since `BLANK_CYCLES`>0).
  - `segments` = dash: 7'b0111111 when active-low, 7'b1000000 when active-high.
- `rx_valid` sampled at edge N updates the buffer at N. If the digit is in DRIVE, `segments` reflects it after edge N+1, i.e. 2-cycle latency.
- Slot length is exactly `SCAN_DIV` cycles: the first `BLANK_CYCLES` cycles are blanked and the remaining `SCAN_DIV`-`BLANK_CYCLES` are driven. The full frame is 2*`NUM_BYTES`*`SCAN_DIV` cycles.
- `BLANK_CYCLES`=0 means no blanking, and `dig_sel` is driven from cycle 1 after reset.
- Back-to-back `rx_valid` on every cycle is accepted with no loss.
- A reset mid-slot restarts the scan at digit 0 and clears all dashes.

## Structure
- Shared package `ssd_pkg`:
  - dash constant.
  - blank constant.
  - glyph table localparams for 0–F.
  - segment bit-order definition.
  - polarity helper function.
- One sub-module, `ssd_hex_decoder`: combinational; 4-bit nibble plus dash in, 7-bit active-high glyph out. The top level applies `SEG_ACTIVE_LOW` inversion before the output register.
- Buffer, write pointer, prescaler and scan FSM live in the top level.

## Test plan
All scenarios use `NUM_BYTES`=2, `SCAN_DIV`=8, `BLANK_CYCLES`=2 and active-low polarity.
- Reset, no rx:
  - `dig_sel` cycles 1111 (2 cycles) → 1110 (6 cycles) → 1111 → 1101 … → 0111.
  - `segments`=7'b0111111 in every DRIVE slot.
- Shift mode, send 0xA5:
  - Digit 0 shows 5 (7'b0010010) and digit 1 shows A (7'b0001000).
  - Digits 2 and 3 still show dash.
- Shift mode, send 0x12 then 0x34:
  - Digits 0–3 show 4, 3, 2, 1.
  - Sending 0x56 next drops 0x12, so the digits show 6, 5, 4, 3.
- Overwrite mode, send 0x11, 0x22, 0x33:
  - `byte_q[0]`=0x33 and `byte_q[1]`=0x22, so digits read 3, 3, 2, 2.
  - `wr_ptr`=1 after the wrap.
- `rx_valid` coincident with slot terminal count while digit 0 is active: byte 0x0F is captured, and digit 0 shows F on its next DRIVE slot, no strobe lost.
- `rst` asserted mid-DRIVE of digit 2 together with `rx_valid`=1:
  - Next cycle `dig_sel`=1111, `segments`=dash, all `written`=0.
  - The byte is not stored.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared definitions for the seven-segment scan display.
//   - segment bit order {g,f,e,d,c,b,a}, glyphs stored active-high
//   - dash / blank constants, hex glyph table 0..F (lowercase b and d)
//   - scan slot state type
//   - seg_polarity(): maps an active-high glyph onto the pin polarity
package ssd_pkg;

    // Bit positions inside a 7-bit segment vector.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_DASH  = 7'b100_0000;
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    function automatic logic [6:0] seg_polarity(input logic [6:0] glyph, input bit active_low);
        return active_low ? ~glyph : glyph;
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// ssd_hex_decoder: combinational nibble-to-glyph decoder.
//   nibble_i [3:0] : hex value to show
//   dash_i         : entry never written, show a dash instead
//   glyph_o  [6:0] : active-high segments {g,f,e,d,c,b,a}
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dash_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = SEG_BLANK;
        if (dash_i) begin
            glyph_o = SEG_DASH;
        end else begin
            case (nibble_i)
                4'h0:    glyph_o = GLYPH_0;
                4'h1:    glyph_o = GLYPH_1;
                4'h2:    glyph_o = GLYPH_2;
                4'h3:    glyph_o = GLYPH_3;
                4'h4:    glyph_o = GLYPH_4;
                4'h5:    glyph_o = GLYPH_5;
                4'h6:    glyph_o = GLYPH_6;
                4'h7:    glyph_o = GLYPH_7;
                4'h8:    glyph_o = GLYPH_8;
                4'h9:    glyph_o = GLYPH_9;
                4'hA:    glyph_o = GLYPH_A;
                4'hB:    glyph_o = GLYPH_B;
                4'hC:    glyph_o = GLYPH_C;
                4'hD:    glyph_o = GLYPH_D;
                4'hE:    glyph_o = GLYPH_E;
                default: glyph_o = GLYPH_F;
            endcase
        end
    end

endmodule

// File: rtl/uart_ssd_scan_display.sv
// uart_ssd_scan_display: shows received UART bytes as hex digits on a
// time-multiplexed seven-segment bank (two digits per byte, digit 0 rightmost).
//   clk              : system clock
//   rst              : synchronous active-high reset
//   rx_data  [7:0]   : received byte
//   rx_valid         : one-cycle strobe qualifying rx_data
//   segments [6:0]   : {g,f,e,d,c,b,a}, registered, polarity set by SEG_ACTIVE_LOW
//   dig_sel  [2N-1:0]: one-hot active-low digit enable, registered
//
// Scan slot states (derived from the prescaler each cycle):
//   state    | meaning
//   ST_BLANK | div_cnt < BLANK_CYCLES, all digits off to stop ghosting
//   ST_DRIVE | rest of the slot, digit dig_idx enabled
module uart_ssd_scan_display
    import ssd_pkg::*;
#(
    parameter int NUM_BYTES      = 2,
    parameter int SCAN_DIV       = 416_667,
    parameter int BLANK_CYCLES   = 500,
    parameter int SHIFT_MODE     = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [6:0]             segments,
    output logic [2*NUM_BYTES-1:0] dig_sel
);

    localparam int NUM_DIGITS = 2 * NUM_BYTES;
    localparam int DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int PTR_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam bit ACT_LOW    = (SEG_ACTIVE_LOW != 0);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_BYTES - 1);

    // ------------------------------------------------------------------
    // Display buffer
    // ------------------------------------------------------------------
    logic [NUM_BYTES-1:0][7:0] byte_q, byte_d;
    logic [NUM_BYTES-1:0]      written_q, written_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;

    always_comb begin
        byte_d    = byte_q;
        written_d = written_q;
        wr_ptr_d  = wr_ptr_q;
        if (rx_valid) begin
            if (SHIFT_MODE != 0) begin
                for (int k = NUM_BYTES - 1; k > 0; k--) begin
                    byte_d[k]    = byte_q[k-1];
                    written_d[k] = written_q[k-1];
                end
                byte_d[0]    = rx_data;
                written_d[0] = 1'b1;
            end else begin
                for (int k = 0; k < NUM_BYTES; k++) begin
                    if (wr_ptr_q == PTR_W'(k)) begin
                        byte_d[k]    = rx_data;
                        written_d[k] = 1'b1;
                    end
                end
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_q    <= '0;
            written_q <= '0;
            wr_ptr_q  <= '0;
        end else begin
            byte_q    <= byte_d;
            written_q <= written_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] dig_idx_q, dig_idx_d;
    logic             slot_tc;
    scan_state_e      state_d;

    always_comb begin
        slot_tc   = (div_cnt_q == DIV_LAST);
        div_cnt_d = slot_tc ? '0 : div_cnt_q + DIV_W'(1);
        dig_idx_d = dig_idx_q;
        if (slot_tc) begin
            dig_idx_d = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + IDX_W'(1);
        end
        state_d = (div_cnt_d < BLANK_END) ? ST_BLANK : ST_DRIVE;
    end

    // ------------------------------------------------------------------
    // Glyph selection. Outputs are registered from next-cycle scan values
    // so dig_sel and segments line up with div_cnt/dig_idx, while the
    // buffer contribution is the current byte_q (one extra cycle of
    // latency from rx_valid to the pins).
    // ------------------------------------------------------------------
    logic [3:0] nibble;
    logic       nib_dash;
    logic [6:0] glyph;
    logic [6:0] seg_d;
    logic [NUM_DIGITS-1:0] dig_sel_d;

    always_comb begin
        nibble   = 4'h0;
        nib_dash = 1'b1;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (dig_idx_d == IDX_W'(2 * k)) begin
                nibble   = byte_q[k][3:0];
                nib_dash = ~written_q[k];
            end else if (dig_idx_d == IDX_W'(2 * k + 1)) begin
                nibble   = byte_q[k][7:4];
                nib_dash = ~written_q[k];
            end
        end
    end

    ssd_hex_decoder u_dec (
        .nibble_i (nibble),
        .dash_i   (nib_dash),
        .glyph_o  (glyph)
    );

    always_comb begin
        seg_d     = seg_polarity(glyph, ACT_LOW);
        dig_sel_d = '1;
        if (state_d == ST_DRIVE) begin
            dig_sel_d = ~(NUM_DIGITS'(1) << dig_idx_d);
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM with registered outputs
    // ------------------------------------------------------------------
    logic [6:0]            segments_q;
    logic [NUM_DIGITS-1:0] dig_sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            dig_idx_q  <= '0;
            dig_sel_q  <= '1;
            segments_q <= seg_polarity(SEG_DASH, ACT_LOW);
        end else begin
            div_cnt_q  <= div_cnt_d;
            dig_idx_q  <= dig_idx_d;
            dig_sel_q  <= dig_sel_d;
            segments_q <= seg_d;
        end
    end

    assign segments = segments_q;
    assign dig_sel  = dig_sel_q;

endmodule

// File: tb/tb_uart_ssd_scan_display.sv
module tb_uart_ssd_scan_display;

    localparam logic [6:0] L_DASH = 7'b0111111;
    localparam logic [6:0] L_0 = 7'b1000000;
    localparam logic [6:0] L_1 = 7'b1111001;
    localparam logic [6:0] L_2 = 7'b0100100;
    localparam logic [6:0] L_3 = 7'b0110000;
    localparam logic [6:0] L_4 = 7'b0011001;
    localparam logic [6:0] L_5 = 7'b0010010;
    localparam logic [6:0] L_6 = 7'b0000010;
    localparam logic [6:0] L_A = 7'b0001000;
    localparam logic [6:0] L_F = 7'b0001110;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid_sh = 1'b0;
    logic       rx_valid_ow = 1'b0;
    logic [6:0] seg_sh, seg_ow;
    logic [3:0] dig_sel_sh, dig_sel_ow;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    uart_ssd_scan_display #(
        .NUM_BYTES(2), .SCAN_DIV(8), .BLANK_CYCLES(2), .SHIFT_MODE(1), .SEG_ACTIVE_LOW(1)
    ) u_dut_sh (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_sh),
        .segments(seg_sh), .dig_sel(dig_sel_sh)
    );

    uart_ssd_scan_display #(
        .NUM_BYTES(2), .SCAN_DIV(8), .BLANK_CYCLES(2), .SHIFT_MODE(0), .SEG_ACTIVE_LOW(1)
    ) u_dut_ow (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_ow),
        .segments(seg_ow), .dig_sel(dig_sel_ow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Leaves the bench on the negedge of cycle 0 (div_cnt=0, dig_idx=0).
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input bit ow, input logic [7:0] b);
        rx_data = b;
        if (ow) rx_valid_ow = 1'b1; else rx_valid_sh = 1'b1;
        @(negedge clk);
        rx_valid_ow = 1'b0;
        rx_valid_sh = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_digit(input string tag, input bit ow, input int d, input logic [6:0] exp);
        logic [3:0] tgt;
        logic [6:0] seg;
        bit         found;
        tgt   = ~(4'b0001 << d);
        seg   = 7'h00;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if ((ow ? dig_sel_ow : dig_sel_sh) == tgt) begin
                found = 1'b1;
                seg   = ow ? seg_ow : seg_sh;
            end
        end
        chk({tag, "_found"}, 32'(found), 32'd1);
        chk(tag, 32'(seg), 32'(exp));
    endtask

    initial begin
        logic [3:0] exp_sel;
        int         didx;

        // Reset, no rx: frame pattern and dashes
        do_reset();
        for (int k = 0; k < 32; k++) begin
            didx    = k / 8;
            exp_sel = ((k % 8) < 2) ? 4'b1111 : ~(4'b0001 << didx);
            chk($sformatf("rst_sel_c%0d", k), 32'(dig_sel_sh), 32'(exp_sel));
            if ((k % 8) >= 2)
                chk($sformatf("rst_seg_c%0d", k), 32'(seg_sh), 32'(L_DASH));
            if (k == 0)
                chk("rst_seg_c0", 32'(seg_sh), 32'(L_DASH));
            @(negedge clk);
        end

        // Shift mode: 0xA5
        send(1'b0, 8'hA5);
        check_digit("a5_d0", 1'b0, 0, L_5);
        check_digit("a5_d1", 1'b0, 1, L_A);
        check_digit("a5_d2", 1'b0, 2, L_DASH);
        check_digit("a5_d3", 1'b0, 3, L_DASH);

        // Shift mode: 0x12, 0x34, then 0x56
        do_reset();
        send(1'b0, 8'h12);
        send(1'b0, 8'h34);
        check_digit("s34_d0", 1'b0, 0, L_4);
        check_digit("s34_d1", 1'b0, 1, L_3);
        check_digit("s34_d2", 1'b0, 2, L_2);
        check_digit("s34_d3", 1'b0, 3, L_1);
        send(1'b0, 8'h56);
        check_digit("s56_d0", 1'b0, 0, L_6);
        check_digit("s56_d1", 1'b0, 1, L_5);
        check_digit("s56_d2", 1'b0, 2, L_4);
        check_digit("s56_d3", 1'b0, 3, L_3);

        // Overwrite mode: 0x11, 0x22, 0x33 wraps; 0x44 lands in entry 1
        send(1'b1, 8'h11);
        send(1'b1, 8'h22);
        send(1'b1, 8'h33);
        check_digit("ow_d0", 1'b1, 0, L_3);
        check_digit("ow_d1", 1'b1, 1, L_3);
        check_digit("ow_d2", 1'b1, 2, L_2);
        check_digit("ow_d3", 1'b1, 3, L_2);
        send(1'b1, 8'h44);
        check_digit("ow44_d0", 1'b1, 0, L_3);
        check_digit("ow44_d2", 1'b1, 2, L_4);
        check_digit("ow44_d3", 1'b1, 3, L_4);

        // rx_valid on the slot terminal count of digit 0
        do_reset();
        repeat (7) @(negedge clk);
        rx_data     = 8'h0F;
        rx_valid_sh = 1'b1;
        @(negedge clk);
        rx_valid_sh = 1'b0;
        chk("tc_sel_c8", 32'(dig_sel_sh), 32'(4'b1111));
        repeat (2) @(negedge clk);
        chk("tc_sel_c10", 32'(dig_sel_sh), 32'(4'b1101));
        chk("tc_seg_c10", 32'(seg_sh), 32'(L_0));
        check_digit("tc_d0", 1'b0, 0, L_F);

        // Reset mid-DRIVE of digit 2 together with rx_valid
        do_reset();
        repeat (20) @(negedge clk);
        chk("mid_sel_c20", 32'(dig_sel_sh), 32'(4'b1011));
        rst         = 1'b1;
        rx_valid_sh = 1'b1;
        rx_data     = 8'h77;
        @(negedge clk);
        chk("mid_rst_sel", 32'(dig_sel_sh), 32'(4'b1111));
        chk("mid_rst_seg", 32'(seg_sh), 32'(L_DASH));
        rst         = 1'b0;
        rx_valid_sh = 1'b0;
        check_digit("mid_d0", 1'b0, 0, L_DASH);
        check_digit("mid_d1", 1'b0, 1, L_DASH);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
